// File: rtl/exe_mem_req_pkg.sv
// Shared constants and types for the EXE-stage memory request unit.
package exe_mem_req_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  localparam int unsigned EMR_CNT_W = 2;

  typedef enum logic [1:0] {
    EMR_IDLE,
    EMR_REQ,
    EMR_ACK
  } emr_state_e;

endpackage

// File: rtl/exe_mem_req_if.sv
// Data-SRAM request/response channel between the EXE issue unit and memory.
interface exe_mem_req_if;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;

  modport master (
    output data_sram_req,
    output data_sram_wr,
    output data_sram_size,
    output data_sram_addr,
    output data_sram_wstrb,
    output data_sram_wdata,
    input  data_sram_addr_ok,
    input  data_sram_data_ok
  );

  modport slave (
    input  data_sram_req,
    input  data_sram_wr,
    input  data_sram_size,
    input  data_sram_addr,
    input  data_sram_wstrb,
    input  data_sram_wdata,
    output data_sram_addr_ok,
    output data_sram_data_ok
  );

endinterface

// File: rtl/exe_mem_req_mem_store_align.sv
// Byte-lane strobes, replicated write data and misalignment detect for one access.
module mem_store_align
  import exe_mem_req_pkg::*;
(
  input  logic [1:0]  mem_size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic        op_store,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        misalign
);

  // Decode size into lanes; loads never assert strobes.
  always_comb begin
    wstrb    = 4'h0;
    wdata    = store_data;
    misalign = 1'b0;
    case (mem_size)
      MEM_SIZE_B: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      MEM_SIZE_H: begin
        wstrb    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata    = {2{store_data[15:0]}};
        misalign = addr_lo[0];
      end
      default: begin
        wstrb    = 4'hF;
        misalign = |addr_lo;
      end
    endcase
    if (!op_store) begin
      wstrb = 4'h0;
    end
  end

endmodule

// File: rtl/exe_mem_req.sv
// EXE-stage data-SRAM request issue with outstanding/discard tracking.
// Optional build macro EXE_ALE_CHECK_EN: misaligned accesses raise es_ale and
// issue no request; without it es_ale is 0 and the raw address is sent.
module exe_mem_req
  import exe_mem_req_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          es_valid,
  input  logic          op_load,
  input  logic          op_store,
  input  logic [1:0]    mem_size,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   store_data,
  input  logic          es_pre_ex,
  input  logic          ms_ex,
  input  logic          wb_ex,
  input  logic          ms_allowin,
  output logic          es_mem_ready,
  output logic          es_ale,
  output logic          es_wait_data_ok,
  output logic          ms_data_ok,
  exe_mem_req_if.master sram
);

  emr_state_e           state_q, state_d;
  logic                 cancel_q, cancel_d;
  logic [EMR_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [EMR_CNT_W-1:0] discard_q, discard_d;

  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;

  logic        mem_op, misalign, kill, issue, accept, ready_st;
  logic        addr_ok, data_ok;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;

  assign addr_ok = sram.data_sram_addr_ok;
  assign data_ok = sram.data_sram_data_ok;
  assign mem_op  = op_load | op_store;

  mem_store_align u_align (
    .mem_size   (mem_size),
    .addr_lo    (mem_addr[1:0]),
    .store_data (store_data),
    .op_store   (op_store),
    .wstrb      (wstrb_c),
    .wdata      (wdata_c),
    .misalign   (misalign)
  );

`ifdef EXE_ALE_CHECK_EN
  assign es_ale = es_valid & mem_op & misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign es_ale          = 1'b0;
`endif

  assign kill            = es_pre_ex | es_ale | ms_ex | wb_ex;
  assign issue           = es_valid & mem_op & ~kill;
  assign accept          = sram.data_sram_req & addr_ok;
  assign es_wait_data_ok = mem_op & ~kill;
  assign ms_data_ok      = data_ok & (discard_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMR_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: once a request is on the bus it is held until accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMR_IDLE: begin
        if (issue && addr_ok)  state_d = ms_allowin ? EMR_IDLE : EMR_ACK;
        else if (issue)        state_d = EMR_REQ;
      end
      EMR_REQ: begin
        if (addr_ok) begin
          if (cancel_q || wb_ex) state_d = EMR_IDLE;
          else                   state_d = ms_allowin ? EMR_IDLE : EMR_ACK;
        end
      end
      EMR_ACK: begin
        if (wb_ex || (ms_allowin && es_valid)) state_d = EMR_IDLE;
      end
      default: state_d = EMR_IDLE;
    endcase
  end

  // Outputs: IDLE drives the live operands, REQ replays the captured ones.
  always_comb begin
    sram.data_sram_req   = 1'b0;
    sram.data_sram_wr    = op_store;
    sram.data_sram_size  = mem_size;
    sram.data_sram_addr  = mem_addr;
    sram.data_sram_wstrb = wstrb_c;
    sram.data_sram_wdata = wdata_c;
    ready_st             = 1'b0;
    unique case (state_q)
      EMR_IDLE: begin
        sram.data_sram_req = issue;
        ready_st           = addr_ok;
      end
      EMR_REQ: begin
        sram.data_sram_req   = 1'b1;
        sram.data_sram_wr    = wr_q;
        sram.data_sram_size  = size_q;
        sram.data_sram_addr  = addr_q;
        sram.data_sram_wstrb = wstrb_q;
        sram.data_sram_wdata = wdata_q;
        ready_st             = addr_ok & ~cancel_q;
      end
      EMR_ACK:  ready_st = 1'b1;
      default:  ready_st = 1'b0;
    endcase
    // SRAM side sees the reset in the same cycle, even mid-REQ.
    if (reset) sram.data_sram_req = 1'b0;
    es_mem_ready = es_valid & (~mem_op | kill | ready_st);
  end

  // Capture the request operands while it is first presented from IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wstrb_q <= 4'h0;
      wdata_q <= '0;
    end else if (state_q == EMR_IDLE && issue) begin
      wr_q    <= op_store;
      size_q  <= mem_size;
      addr_q  <= mem_addr;
      wstrb_q <= wstrb_c;
      wdata_q <= wdata_c;
    end
  end

  // Cancel flag and outstanding/discard counter next-state.
  always_comb begin
    out_cnt_d = out_cnt_q + EMR_CNT_W'(accept) - EMR_CNT_W'(data_ok);
    cancel_d  = 1'b0;
    discard_d = discard_q;
    if (state_q == EMR_REQ) begin
      cancel_d = addr_ok ? 1'b0 : (cancel_q | wb_ex);
    end
    if (wb_ex) begin
      // A REQ accepted this very cycle is already part of out_cnt_d.
      discard_d = out_cnt_d;
    end else begin
      if (state_q == EMR_REQ && addr_ok && cancel_q) discard_d = discard_d + EMR_CNT_W'(1);
      if (data_ok && discard_q != '0)                 discard_d = discard_d - EMR_CNT_W'(1);
    end
  end

  // Counter and cancel registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cancel_q  <= 1'b0;
      out_cnt_q <= '0;
      discard_q <= '0;
    end else begin
      cancel_q  <= cancel_d;
      out_cnt_q <= out_cnt_d;
      discard_q <= discard_d;
    end
  end

  out_cnt_limit: assert property (@(posedge clk) disable iff (reset)
    out_cnt_q != EMR_CNT_W'(3));

endmodule

// File: tb/tb_exe_mem_req.sv
// Directed bench for exe_mem_req: vector table plus multi-cycle sequences.
module tb_exe_mem_req;
  import exe_mem_req_pkg::*;

`ifdef EXE_ALE_CHECK_EN
  localparam bit AleEn = 1'b1;
`else
  localparam bit AleEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        es_valid, op_load, op_store, es_pre_ex, ms_ex, wb_ex, ms_allowin;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, store_data;
  logic        es_mem_ready, es_ale, es_wait_data_ok, ms_data_ok;

  exe_mem_req_if sram_if ();

  exe_mem_req dut (
    .clk             (clk),
    .reset           (reset),
    .es_valid        (es_valid),
    .op_load         (op_load),
    .op_store        (op_store),
    .mem_size        (mem_size),
    .mem_addr        (mem_addr),
    .store_data      (store_data),
    .es_pre_ex       (es_pre_ex),
    .ms_ex           (ms_ex),
    .wb_ex           (wb_ex),
    .ms_allowin      (ms_allowin),
    .es_mem_ready    (es_mem_ready),
    .es_ale          (es_ale),
    .es_wait_data_ok (es_wait_data_ok),
    .ms_data_ok      (ms_data_ok),
    .sram            (sram_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v, ld, st;
    logic [1:0]  sz;
    logic [31:0] addr, sd;
    logic        pre_ex, ms_ex, mis;
    logic        e_req;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic        e_ready, e_wait;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    es_valid = v; op_load = ld; op_store = st; mem_size = sz; mem_addr = a; store_data = d;
    es_pre_ex = 1'b0; ms_ex = 1'b0; wb_ex = 1'b0;
  endtask

  initial begin
    logic e_req, e_ale, e_ready, e_wait;

    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    ms_allowin = 1'b1;
    sram_if.data_sram_addr_ok = 1'b0;
    sram_if.data_sram_data_ok = 1'b0;

    //             v  ld st sz          addr          sd            pex mex mis req wstrb    wdata        rdy wait
    vt[0]  = '{1, 0, 1, MEM_SIZE_B, 32'h0000_1003, 32'h0000_00AB, 0, 0, 0, 1, 4'b1000, 32'hABAB_ABAB, 1, 1};
    vt[1]  = '{1, 0, 1, MEM_SIZE_H, 32'h0000_1002, 32'h1234_CDEF, 0, 0, 0, 1, 4'b1100, 32'hCDEF_CDEF, 1, 1};
    vt[2]  = '{1, 0, 1, MEM_SIZE_H, 32'h0000_1000, 32'h9876_1357, 0, 0, 0, 1, 4'b0011, 32'h1357_1357, 1, 1};
    vt[3]  = '{1, 0, 1, MEM_SIZE_W, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 0, 1, 4'b1111, 32'hDEAD_BEEF, 1, 1};
    vt[4]  = '{1, 0, 1, MEM_SIZE_B, 32'h0000_1001, 32'h0000_005A, 0, 0, 0, 1, 4'b0010, 32'h5A5A_5A5A, 1, 1};
    vt[5]  = '{1, 1, 0, MEM_SIZE_W, 32'h0000_2000, 32'h1122_3344, 0, 0, 0, 1, 4'b0000, 32'h0,         1, 1};
    vt[6]  = '{1, 1, 0, MEM_SIZE_H, 32'h0000_2001, 32'h0,         0, 0, 1, 1, 4'b0000, 32'h0,         1, 1};
    vt[7]  = '{1, 0, 1, MEM_SIZE_W, 32'h0000_1002, 32'hCAFE_F00D, 0, 0, 1, 1, 4'b1111, 32'hCAFE_F00D, 1, 1};
    vt[8]  = '{1, 0, 1, MEM_SIZE_W, 32'h0000_3000, 32'h0,         0, 1, 0, 0, 4'b0000, 32'h0,         1, 0};
    vt[9]  = '{1, 1, 0, MEM_SIZE_W, 32'h0000_3004, 32'h0,         1, 0, 0, 0, 4'b0000, 32'h0,         1, 0};
    vt[10] = '{1, 0, 0, MEM_SIZE_W, 32'h0000_3008, 32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,         1, 0};
    vt[11] = '{0, 0, 1, MEM_SIZE_W, 32'h0000_300C, 32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,         0, 1};
    vt[12] = '{1, 0, 1, MEM_SIZE_B, 32'h0000_1002, 32'h0000_0077, 0, 0, 0, 1, 4'b0100, 32'h7777_7777, 1, 1};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    chk("rst_req", sram_if.data_sram_req, 1'b0);
    chk("rst_ready", es_mem_ready, 1'b0);
    chk("rst_ale", es_ale, 1'b0);
    chk("rst_ms_data_ok", ms_data_ok, 1'b0);
    cyc();

    // Single-cycle issue table: addr_ok and data_ok together keep out_cnt at 0.
    for (int i = 0; i < NV; i++) begin
      e_ale   = vt[i].mis & AleEn;
      e_req   = vt[i].e_req & ~e_ale;
      e_ready = vt[i].e_ready | e_ale;
      e_wait  = vt[i].e_wait & ~e_ale;
      drive(vt[i].v, vt[i].ld, vt[i].st, vt[i].sz, vt[i].addr, vt[i].sd);
      es_pre_ex = vt[i].pre_ex;
      ms_ex     = vt[i].ms_ex;
      sram_if.data_sram_addr_ok = 1'b1;
      sram_if.data_sram_data_ok = e_req;
      #2;
      chk($sformatf("v%0d_req", i), sram_if.data_sram_req, e_req);
      chk($sformatf("v%0d_ready", i), es_mem_ready, e_ready);
      chk($sformatf("v%0d_ale", i), es_ale, e_ale);
      chk($sformatf("v%0d_wait", i), es_wait_data_ok, e_wait);
      chk($sformatf("v%0d_ms_data_ok", i), ms_data_ok, e_req);
      if (e_req) begin
        chk($sformatf("v%0d_addr", i), sram_if.data_sram_addr, vt[i].addr);
        chk($sformatf("v%0d_size", i), sram_if.data_sram_size, vt[i].sz);
        chk($sformatf("v%0d_wr", i), sram_if.data_sram_wr, vt[i].st);
        chk($sformatf("v%0d_wstrb", i), sram_if.data_sram_wstrb, vt[i].e_wstrb);
        if (vt[i].st) chk($sformatf("v%0d_wdata", i), sram_if.data_sram_wdata, vt[i].e_wdata);
      end
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    sram_if.data_sram_addr_ok = 1'b0;
    sram_if.data_sram_data_ok = 1'b0;
    cyc();

    // ld.w held for three cycles; operands must stay captured.
    drive(1'b1, 1'b1, 1'b0, MEM_SIZE_W, 32'h0000_2000, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) mem_addr = 32'hFFFF_0000 + 32'(16 * k);
      sram_if.data_sram_addr_ok = (k == 3);
      #2;
      chk($sformatf("hold%0d_req", k), sram_if.data_sram_req, 1'b1);
      chk($sformatf("hold%0d_addr", k), sram_if.data_sram_addr, 32'h0000_2000);
      chk($sformatf("hold%0d_ready", k), es_mem_ready, (k == 3));
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    sram_if.data_sram_addr_ok = 1'b0;
    sram_if.data_sram_data_ok = 1'b1;
    #2;
    chk("hold_done_req", sram_if.data_sram_req, 1'b0);
    chk("hold_data_ok", ms_data_ok, 1'b1);
    cyc();
    sram_if.data_sram_data_ok = 1'b0;

    // Accepted while MEM is stalled: ACK holds readiness without reissue.
    drive(1'b1, 1'b0, 1'b1, MEM_SIZE_W, 32'h0000_3000, 32'h0102_0304);
    ms_allowin = 1'b0;
    sram_if.data_sram_addr_ok = 1'b1;
    #2;
    chk("ack0_req", sram_if.data_sram_req, 1'b1);
    chk("ack0_ready", es_mem_ready, 1'b1);
    cyc();
    sram_if.data_sram_addr_ok = 1'b0;
    #2;
    chk("ack1_req", sram_if.data_sram_req, 1'b0);
    chk("ack1_ready", es_mem_ready, 1'b1);
    cyc();
    ms_allowin = 1'b1;
    #2;
    chk("ack2_req", sram_if.data_sram_req, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    sram_if.data_sram_data_ok = 1'b1;
    #2;
    chk("ack_data_ok", ms_data_ok, 1'b1);
    cyc();
    drive(1'b1, 1'b1, 1'b0, MEM_SIZE_W, 32'h0000_3010, 32'h0);
    sram_if.data_sram_addr_ok = 1'b1;
    #2;
    chk("ack_idle_again_req", sram_if.data_sram_req, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    sram_if.data_sram_addr_ok = 1'b0;
    sram_if.data_sram_data_ok = 1'b0;
    cyc();

    // wb_ex during REQ: the late-accepted request's data_ok is swallowed.
    drive(1'b1, 1'b1, 1'b0, MEM_SIZE_W, 32'h0000_4000, 32'h0);
    #2;
    chk("cxl0_req", sram_if.data_sram_req, 1'b1);
    cyc();
    drive(1'b0, 1'b1, 1'b0, MEM_SIZE_W, 32'h0000_0000, 32'h0);
    wb_ex = 1'b1;
    #2;
    chk("cxl1_req", sram_if.data_sram_req, 1'b1);
    chk("cxl1_wait", es_wait_data_ok, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    #2;
    chk("cxl2_req", sram_if.data_sram_req, 1'b1);
    cyc();
    sram_if.data_sram_addr_ok = 1'b1;
    #2;
    chk("cxl3_addr", sram_if.data_sram_addr, 32'h0000_4000);
    cyc();
    sram_if.data_sram_addr_ok = 1'b0;
    #2;
    chk("cxl4_req", sram_if.data_sram_req, 1'b0);
    cyc();
    drive(1'b1, 1'b1, 1'b0, MEM_SIZE_W, 32'h0000_5000, 32'h0);
    sram_if.data_sram_addr_ok = 1'b1;
    #2;
    chk("cxl5_ready", es_mem_ready, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    sram_if.data_sram_addr_ok = 1'b0;
    sram_if.data_sram_data_ok = 1'b1;
    #2;
    chk("cxl_swallow", ms_data_ok, 1'b0);
    cyc();
    #2;
    chk("cxl_pass", ms_data_ok, 1'b1);
    cyc();
    sram_if.data_sram_data_ok = 1'b0;

    // Two outstanding at wb_ex: both responses are dropped.
    drive(1'b1, 1'b1, 1'b0, MEM_SIZE_W, 32'h0000_6000, 32'h0);
    sram_if.data_sram_addr_ok = 1'b1;
    cyc();
    drive(1'b1, 1'b0, 1'b1, MEM_SIZE_W, 32'h0000_6004, 32'h55AA_55AA);
    #2;
    chk("two_st_req", sram_if.data_sram_req, 1'b1);
    chk("two_st_wstrb", sram_if.data_sram_wstrb, 4'hF);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    sram_if.data_sram_addr_ok = 1'b0;
    wb_ex = 1'b1;
    cyc();
    wb_ex = 1'b0;
    sram_if.data_sram_data_ok = 1'b1;
    #2;
    chk("two_swallow0", ms_data_ok, 1'b0);
    cyc();
    #2;
    chk("two_swallow1", ms_data_ok, 1'b0);
    cyc();
    sram_if.data_sram_data_ok = 1'b0;
    drive(1'b1, 1'b1, 1'b0, MEM_SIZE_W, 32'h0000_6008, 32'h0);
    sram_if.data_sram_addr_ok = 1'b1;
    cyc();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    sram_if.data_sram_addr_ok = 1'b0;
    sram_if.data_sram_data_ok = 1'b1;
    #2;
    chk("two_pass", ms_data_ok, 1'b1);
    cyc();
    sram_if.data_sram_data_ok = 1'b0;

    // Reset while a request is pending.
    drive(1'b1, 1'b1, 1'b0, MEM_SIZE_W, 32'h0000_7000, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    reset = 1'b1;
    #2;
    chk("rstreq_req_in_reset", sram_if.data_sram_req, 1'b0);
    cyc();
    reset = 1'b0;
    #2;
    chk("rstreq_req_after", sram_if.data_sram_req, 1'b0);
    cyc();
    drive(1'b1, 1'b0, 1'b1, MEM_SIZE_B, 32'h0000_7101, 32'h0000_003C);
    sram_if.data_sram_addr_ok = 1'b1;
    sram_if.data_sram_data_ok = 1'b1;
    #2;
    chk("rstreq_new_req", sram_if.data_sram_req, 1'b1);
    chk("rstreq_new_addr", sram_if.data_sram_addr, 32'h0000_7101);
    chk("rstreq_new_wstrb", sram_if.data_sram_wstrb, 4'b0010);
    chk("rstreq_new_wdata", sram_if.data_sram_wdata, 32'h3C3C_3C3C);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    sram_if.data_sram_addr_ok = 1'b0;
    sram_if.data_sram_data_ok = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
